fifo_rd_ctrl: RTL and testbench

Parametrised read-side pointer controller for the dual-clock FIFO family used in the AHB2APB bridge. It replaces the fixed-feature read pointer block with the following additions:
- generic depth
- registered empty flag aligned with the gray pointer
- fill-level and almost-empty outputs
- explicit memory read-enable

It sits in the read clock domain. Its inputs are the synchronised gray write pointer and the consumer's read request. It drives the FIFO memory read port and returns the gray read pointer to the write-side synchroniser.

---
 rtl/fifo_rd_ctrl.sv | 95 +++++++++
 tb/tb_fifo_rd_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side pointer controller for the dual-clock FIFO.
// Lives entirely in the r_clk domain. It keeps a binary read pointer and a
// matching gray copy for the write-side synchroniser. From the synchronised
// gray write pointer it derives the registered empty, level and
// almost-empty flags.
// Optional build macro: FIFO_RD_UNDERFLOW_EN enables the sticky underflow flag.
//
// Handshake: r_inc is a request from the consumer. A read is accepted
// (rd_en=1) in any cycle where r_inc=1 and empty=0. There is no back-pressure
// beyond empty: a request made while empty is dropped and does not move the
// pointer.
module fifo_rd_ctrl #(
    parameter int ADDR_W    = 3,
    parameter int AE_THRESH = 1
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              r_inc,
    input  logic [ADDR_W:0]   sync_wr_ptr,
    input  logic              underflow_clr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_level,
    output logic [ADDR_W:0]   gray_rd_ptr,
    output logic              underflow
);

    localparam logic [ADDR_W:0] AE_T = AE_THRESH[ADDR_W:0];

    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] rd_ptr_nxt;
    logic [ADDR_W:0] gray_nxt;
    logic [ADDR_W:0] wr_bin;
    logic [ADDR_W:0] level_nxt;
    logic            rd_fire;

    // Accept a read only when something is stored; the address comes straight
    // from the pointer register, so it never depends on r_inc.
    assign rd_fire = r_inc & ~empty;
    assign rd_en   = rd_fire;
    assign rd_addr = rd_ptr[ADDR_W-1:0];

    assign rd_ptr_nxt = rd_ptr + {{ADDR_W{1'b0}}, rd_fire};
    assign gray_nxt   = rd_ptr_nxt ^ (rd_ptr_nxt >> 1);

    // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
    for (genvar i = 0; i <= ADDR_W; i++) begin : g_wr_bin
        assign wr_bin[i] = ^(sync_wr_ptr >> i);
    end

    // Modulo difference; wraps on protocol violation rather than saturating.
    assign level_nxt = wr_bin - rd_ptr_nxt;

    // Pointer, gray copy and status flags all advance together from rd_ptr_nxt.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            rd_ptr       <= '0;
            gray_rd_ptr  <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
        end else begin
            rd_ptr       <= rd_ptr_nxt;
            gray_rd_ptr  <= gray_nxt;
            empty        <= (gray_nxt == sync_wr_ptr);
            almost_empty <= (level_nxt <= AE_T);
            rd_level     <= level_nxt;
        end
    end

`ifdef FIFO_RD_UNDERFLOW_EN
    logic underflow_q;

    // Sticky read-while-empty flag; a new error wins over a same-cycle clear.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            underflow_q <= 1'b0;
        end else if (r_inc & empty) begin
            underflow_q <= 1'b1;
        end else if (underflow_clr) begin
            underflow_q <= 1'b0;
        end
    end

    assign underflow = underflow_q;
`else
    logic unused_underflow_clr;

    assign unused_underflow_clr = underflow_clr;
    assign underflow            = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed and randomized checks of fifo_rd_ctrl
// (ADDR_W=3, AE_THRESH=1) against a count-based reference model.
module tb_fifo_rd_ctrl;

    localparam int ADDR_W = 3;
    localparam int AE     = 1;
    localparam int DEPTH  = 8;
    localparam int MODP   = 16;

    logic              r_clk = 1'b0;
    logic              r_rst = 1'b1;
    logic              r_inc = 1'b0;
    logic [ADDR_W:0]   sync_wr_ptr = '0;
    logic              underflow_clr = 1'b0;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic              empty;
    logic              almost_empty;
    logic [ADDR_W:0]   rd_level;
    logic [ADDR_W:0]   gray_rd_ptr;
    logic              underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: counts of entries written and read, modulo 2*depth.
    int wr_cnt = 0;
    int m_rd = 0;
    int m_level = 0;
    bit m_empty = 1'b1;
    bit m_ae = 1'b1;
    bit m_uf = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 r_clk = ~r_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    fifo_rd_ctrl #(.ADDR_W(ADDR_W), .AE_THRESH(AE)) dut (
        .r_clk(r_clk), .r_rst(r_rst), .r_inc(r_inc), .sync_wr_ptr(sync_wr_ptr),
        .underflow_clr(underflow_clr), .rd_addr(rd_addr), .rd_en(rd_en),
        .empty(empty), .almost_empty(almost_empty), .rd_level(rd_level),
        .gray_rd_ptr(gray_rd_ptr), .underflow(underflow)
    );

    function automatic logic [3:0] gray4(input int n);
        logic [3:0] b;
        b = 4'(n % MODP);
        return b ^ (b >> 1);
    endfunction

    function automatic bit uf_enabled();
`ifdef FIFO_RD_UNDERFLOW_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_wr(input int n);
        wr_cnt      = n % MODP;
        sync_wr_ptr = gray4(wr_cnt);
    endtask

    // One clock edge; model advances from the inputs held across the edge.
    task automatic tick();
        bit fire;
        bit was_empty;
        was_empty = m_empty;
        fire = r_inc && !m_empty;
        @(posedge r_clk);
        if (r_rst) begin
            m_rd = 0; m_level = 0; m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
        end else begin
            m_rd    = (m_rd + (fire ? 1 : 0)) % MODP;
            m_level = (wr_cnt - m_rd + MODP) % MODP;
            m_empty = (m_level == 0);
            m_ae    = (m_level <= AE);
            if (uf_enabled()) begin
                if (r_inc && was_empty) m_uf = 1'b1;
                else if (underflow_clr) m_uf = 1'b0;
            end
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        r_rst = 1'b1; r_inc = 1'b1; underflow_clr = 1'b0; set_wr(0);
        tick(); tick();
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae: got %b want 1", almost_empty); end
        n_tests++; if (rd_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", rd_level); end
        n_tests++; if (gray_rd_ptr !== 4'b0000) begin n_fail++; $display("FAIL reset_gray: got %b want 0000", gray_rd_ptr); end
        n_tests++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_uf: got %b want 0", underflow); end
        r_rst = 1'b0; r_inc = 1'b0;
        tick();
    endtask

    task automatic test_fill_drain();
        set_wr(3);
        tick();
        n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty: got %b want 0", empty); end
        n_tests++; if (rd_level !== 4'd3) begin n_fail++; $display("FAIL fill_level: got %0d want 3", rd_level); end
        n_tests++; if (almost_empty !== 1'b0) begin n_fail++; $display("FAIL fill_ae: got %b want 0", almost_empty); end
        for (int i = 0; i < 3; i++) begin
            r_inc = 1'b1;
            #1;
            n_tests++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL drain_rd_en[%0d]: got %b want 1", i, rd_en); end
            n_tests++; if (rd_addr !== 3'(i)) begin n_fail++; $display("FAIL drain_addr[%0d]: got %0d want %0d", i, rd_addr, i); end
            tick();
            n_tests++; if (rd_level !== 4'(2 - i)) begin n_fail++; $display("FAIL drain_level[%0d]: got %0d want %0d", i, rd_level, 2 - i); end
            n_tests++; if (almost_empty !== ((2 - i) <= AE)) begin n_fail++; $display("FAIL drain_ae[%0d]: got %b want %b", i, almost_empty, (2 - i) <= AE); end
        end
        r_inc = 1'b0;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
        n_tests++; if (gray_rd_ptr !== 4'b0010) begin n_fail++; $display("FAIL drain_gray: got %b want 0010", gray_rd_ptr); end
    endtask

    task automatic test_underflow();
        bit exp_uf;
        exp_uf = uf_enabled();
        r_inc = 1'b1;
        #1;
        n_tests++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL uf_rd_en: got %b want 0", rd_en); end
        tick();
        r_inc = 1'b0;
        n_tests++; if (rd_addr !== 3'd3) begin n_fail++; $display("FAIL uf_addr: got %0d want 3", rd_addr); end
        n_tests++; if (underflow !== exp_uf) begin n_fail++; $display("FAIL uf_set: got %b want %b", underflow, exp_uf); end
        tick();
        n_tests++; if (underflow !== exp_uf) begin n_fail++; $display("FAIL uf_hold: got %b want %b", underflow, exp_uf); end
        r_inc = 1'b1; underflow_clr = 1'b1;
        tick();
        n_tests++; if (underflow !== exp_uf) begin n_fail++; $display("FAIL uf_set_wins: got %b want %b", underflow, exp_uf); end
        r_inc = 1'b0;
        tick();
        underflow_clr = 1'b0;
        n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL uf_clear: got %b want 0", underflow); end
        n_tests++; if (gray_rd_ptr !== 4'b0010) begin n_fail++; $display("FAIL uf_ptr_hold: got %b want 0010", gray_rd_ptr); end
    endtask

    task automatic test_wrap();
        r_rst = 1'b1; set_wr(0); tick(); r_rst = 1'b0;
        set_wr(1); tick();
        for (int i = 0; i < 12; i++) begin
            r_inc = 1'b1;
            if (i < 11) set_wr(i + 2);
            #1;
            n_tests++; if (rd_addr !== 3'(i % DEPTH) || rd_en !== 1'b1) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d/%b want %0d/1", i, rd_addr, rd_en, i % DEPTH); end
            tick();
            if (i == 7) begin
                n_tests++; if (gray_rd_ptr !== 4'b1100) begin n_fail++; $display("FAIL wrap_gray8: got %b want 1100", gray_rd_ptr); end
            end
            if (i < 11) begin
                n_tests++; if (rd_level !== 4'd1 || empty !== 1'b0) begin n_fail++; $display("FAIL wrap_level[%0d]: got %0d/%b want 1/0", i, rd_level, empty); end
            end
        end
        r_inc = 1'b0;
        n_tests++; if (gray_rd_ptr !== 4'b1010) begin n_fail++; $display("FAIL wrap_gray12: got %b want 1010", gray_rd_ptr); end
        n_tests++; if (empty !== 1'b1 || sync_wr_ptr !== 4'b1010) begin n_fail++; $display("FAIL wrap_empty: got %b want 1", empty); end
        n_tests++; if (rd_addr !== 3'd4) begin n_fail++; $display("FAIL wrap_addr_end: got %0d want 4", rd_addr); end
    endtask

    task automatic test_simultaneous();
        set_wr(wr_cnt + 1); tick();
        n_tests++; if (rd_level !== 4'd1) begin n_fail++; $display("FAIL simul_pre: got %0d want 1", rd_level); end
        r_inc = 1'b1; set_wr(wr_cnt + 1);
        #1;
        n_tests++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL simul_rd_en: got %b want 1", rd_en); end
        tick();
        r_inc = 1'b0;
        n_tests++; if (rd_level !== 4'd1 || empty !== 1'b0) begin n_fail++; $display("FAIL simul_level: got %0d/%b want 1/0", rd_level, empty); end
    endtask

    task automatic test_reset_mid();
        r_rst = 1'b1; set_wr(0); tick(); r_rst = 1'b0;
        set_wr(5); tick();
        n_tests++; if (rd_level !== 4'd5) begin n_fail++; $display("FAIL rmid_pre: got %0d want 5", rd_level); end
        r_inc = 1'b1; r_rst = 1'b1;
        tick();
        n_tests++; if (empty !== 1'b1 || almost_empty !== 1'b1 || rd_level !== 4'd0 || gray_rd_ptr !== 4'd0 || rd_addr !== 3'd0 || underflow !== 1'b0)
            begin n_fail++; $display("FAIL rmid_reset: got e=%b ae=%b lvl=%0d g=%b a=%0d uf=%b want 1 1 0 0000 0 0", empty, almost_empty, rd_level, gray_rd_ptr, rd_addr, underflow); end
        r_rst = 1'b0; r_inc = 1'b0;
        tick();
        n_tests++; if (rd_level !== 4'd5 || gray_rd_ptr !== 4'd0) begin n_fail++; $display("FAIL rmid_no_inc: got %0d/%b want 5/0000", rd_level, gray_rd_ptr); end
    endtask

    task automatic test_random();
        r_rst = 1'b1; set_wr(0); tick(); r_rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            r_rst = ($urandom_range(0, 59) == 0);
            r_inc = $urandom_range(0, 1);
            underflow_clr = ($urandom_range(0, 7) == 0);
            if (r_rst) set_wr(0);
            else if (((wr_cnt - m_rd + MODP) % MODP) < DEPTH && $urandom_range(0, 1) == 1) set_wr(wr_cnt + 1);
            #1;
            n_tests++; if (rd_en !== (r_inc && !m_empty)) begin n_fail++; $display("FAIL rand_rd_en[%0d]: got %b want %b", c, rd_en, r_inc && !m_empty); end
            n_tests++; if (rd_addr !== 3'(m_rd % DEPTH)) begin n_fail++; $display("FAIL rand_addr[%0d]: got %0d want %0d", c, rd_addr, m_rd % DEPTH); end
            tick();
            n_tests++; if (rd_level !== 4'(m_level) || empty !== m_empty || almost_empty !== m_ae)
                begin n_fail++; $display("FAIL rand_status[%0d]: got %0d/%b/%b want %0d/%b/%b", c, rd_level, empty, almost_empty, m_level, m_empty, m_ae); end
            n_tests++; if (gray_rd_ptr !== gray4(m_rd)) begin n_fail++; $display("FAIL rand_gray[%0d]: got %b want %b", c, gray_rd_ptr, gray4(m_rd)); end
            n_tests++; if (underflow !== m_uf) begin n_fail++; $display("FAIL rand_uf[%0d]: got %b want %b", c, underflow, m_uf); end
        end
        r_rst = 1'b0; r_inc = 1'b0; underflow_clr = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        @(posedge r_clk); #1;
        test_reset();
        test_fill_drain();
        test_underflow();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
